// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, NOP encoding and fetch-stage state type.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load enable and +4 adder.
// Define FETCH_ALIGN_EN to force every loaded PC onto a word boundary.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] npc,
    output logic [WORD_W-1:0] load_val,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4
);

    // load_val is shared with the fetch address register so both see the same value
`ifdef FETCH_ALIGN_EN
    assign load_val = {npc[WORD_W-1:2], 2'b00};
`else
    assign load_val = npc;
`endif

    assign pc_plus4 = pc + WORD_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch handshake, stall and redirect handling.
// Define FETCH_ALIGN_EN to word-align every PC/fetch-address load.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] npc,
    input  logic              redirect,
    input  logic              stall,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid
);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic              pc_load;
    logic [WORD_W-1:0] load_val;
    logic [WORD_W-1:0] addr_nxt;
    logic [WORD_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic              req_nxt;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .npc      (npc),
        .load_val (load_val),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= INSTR_NOP;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
        end
    end

    // Next-state and datapath control; redirect beats stall beats ack
    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        addr_nxt  = imem_addr;
        instr_nxt = instr;
        valid_nxt = instr_valid;

        case (state)
            IDLE: begin
                addr_nxt  = pc;
                state_nxt = REQ;
            end
            REQ: begin
                if (redirect) begin
                    pc_load   = 1'b1;
                    valid_nxt = 1'b0;
                    if (imem_ack) begin
                        addr_nxt = load_val;
                    end else begin
                        // address must stay put until the orphaned fetch completes
                        state_nxt = DISCARD;
                    end
                end else if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                    if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        pc_load  = 1'b1;
                        addr_nxt = load_val;
                    end
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    pc_load   = 1'b1;
                    addr_nxt  = load_val;
                    valid_nxt = 1'b0;
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                valid_nxt = 1'b0;
                if (redirect) begin
                    pc_load = 1'b1;
                end
                if (imem_ack) begin
                    addr_nxt  = redirect ? load_val : pc;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_nxt = (state_nxt == REQ) || (state_nxt == DISCARD);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a control-flow model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;

    logic        ack_en;
    logic [31:0] target;

    int n_tests;
    int n_fail;

    fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .redirect    (redirect),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // memory answers combinationally when enabled; next-PC mux selects target on redirect
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem_word(imem_addr);
    assign npc        = redirect ? target : pc_plus4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ack_en = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0;
        #12;
        n_tests++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
        n_tests++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_tests++; if (pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL reset_pc4 got %h want 00400004", pc_plus4); end
        @(negedge clk); rst = 1'b0;
        step();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_req got req=%b addr=%h v=%b want 1 00400000 0", imem_req, imem_addr, instr_valid); end
        step();
        n_tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0040_0000) || imem_addr !== 32'h0040_0004) begin
            n_fail++; $display("FAIL fetch0 got v=%b instr=%h addr=%h want 1 %h 00400004", instr_valid, instr, imem_addr, mem_word(32'h0040_0000)); end
        step();
        n_tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0040_0004) || imem_addr !== 32'h0040_0008) begin
            n_fail++; $display("FAIL fetch1 got v=%b instr=%h addr=%h want 1 %h 00400008", instr_valid, instr, imem_addr, mem_word(32'h0040_0004)); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (instr !== mem_word(32'h0040_0008) || instr_valid !== 1'b1 || pc !== 32'h0040_0008 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d got instr=%h v=%b pc=%h req=%b want %h 1 00400008 0", i, instr, instr_valid, pc, imem_req, mem_word(32'h0040_0008)); end
        end
        stall = 1'b0;
        step();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release got req=%b addr=%h v=%b want 1 0040000c 0", imem_req, imem_addr, instr_valid); end
        step();
        n_tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0040_000C) || imem_addr !== 32'h0040_0010) begin
            n_fail++; $display("FAIL stall_resume got v=%b instr=%h addr=%h want 1 %h 00400010", instr_valid, instr, imem_addr, mem_word(32'h0040_000C)); end
    endtask

    task automatic test_redirect_wait();
        ack_en = 1'b0; redirect = 1'b1; target = 32'h0040_0100;
        step();
        n_tests++; if (pc !== 32'h0040_0100 || imem_addr !== 32'h0040_0010 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_wait1 got pc=%h addr=%h req=%b v=%b want 00400100 00400010 1 0", pc, imem_addr, imem_req, instr_valid); end
        redirect = 1'b0;
        step();
        n_tests++; if (imem_addr !== 32'h0040_0010 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_wait2 got addr=%h req=%b v=%b want 00400010 1 0", imem_addr, imem_req, instr_valid); end
        ack_en = 1'b1;
        step();
        n_tests++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0040_0100 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL redir_drop got v=%b addr=%h req=%b want 0 00400100 1", instr_valid, imem_addr, imem_req); end
        step();
        n_tests++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h0040_0100) || imem_addr !== 32'h0040_0104) begin
            n_fail++; $display("FAIL redir_target got v=%b instr=%h addr=%h want 1 %h 00400104", instr_valid, instr, imem_addr, mem_word(32'h0040_0100)); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        step();
        n_tests++; if (imem_req !== 1'b0 || pc !== 32'h0040_0104 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL rs_hold got req=%b pc=%h v=%b want 0 00400104 1", imem_req, pc, instr_valid); end
        redirect = 1'b1; target = 32'h0040_0200;
        step();
        n_tests++; if (pc !== 32'h0040_0200 || instr_valid !== 1'b0 || imem_addr !== 32'h0040_0200 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL rs_redirect got pc=%h v=%b addr=%h req=%b want 00400200 0 00400200 1", pc, instr_valid, imem_addr, imem_req); end
        redirect = 1'b0; stall = 1'b0;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; target = 32'hFFFF_FFFC;
        step();
        n_tests++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_load got pc=%h pc4=%h v=%b want fffffffc 0 0", pc, pc_plus4, instr_valid); end
        redirect = 1'b0;
        step();
        n_tests++; if (instr !== mem_word(32'hFFFF_FFFC) || instr_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next got instr=%h v=%b pc=%h addr=%h want %h 1 0 0", instr, instr_valid, pc, imem_addr, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_align();
        logic [31:0] exp;
`ifdef FETCH_ALIGN_EN
        exp = 32'h0040_0100;
`else
        exp = 32'h0040_0103;
`endif
        redirect = 1'b1; target = 32'h0040_0103;
        step();
        n_tests++; if (imem_addr !== exp || pc !== exp) begin
            n_fail++; $display("FAIL align got addr=%h pc=%h want %h", imem_addr, pc, exp); end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        step();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pending got req=%b want 1", imem_req); end
        @(negedge clk); rst = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || pc !== RST_PC || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got req=%b pc=%h v=%b want 0 %h 0", imem_req, pc, instr_valid, RST_PC); end
    endtask

    // program-order model: every delivered word comes from the predicted control-flow PC
    task automatic test_random();
        logic [31:0] flow, prev_addr, addr_b, t;
        logic        stale, prev_wait, req_b, ack_b, accepted;
        int          deliveries;
        flow = RST_PC; stale = 1'b0; prev_wait = 1'b0; prev_addr = '0; deliveries = 0;
        rst = 1'b1; ack_en = 1'b0; stall = 1'b0; redirect = 1'b0;
        #12;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) step();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rand_start got req=%b want 1", imem_req); end
        for (int k = 0; k < 3000; k++) begin
            ack_en   = ($urandom_range(0, 99) < 60);
            stall    = ($urandom_range(0, 99) < 25);
            redirect = ($urandom_range(0, 99) < 10);
            t = $urandom();
            t[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
            target = t;
            #1;
            req_b = imem_req; ack_b = imem_ack; addr_b = imem_addr;
            n_tests++; if (pc_plus4 !== pc + 32'd4) begin
                n_fail++; $display("FAIL rand_pc4 got %h want %h", pc_plus4, pc + 32'd4); end
            if (prev_wait && req_b) begin
                n_tests++; if (addr_b !== prev_addr) begin
                    n_fail++; $display("FAIL rand_addr_stable got %h want %h", addr_b, prev_addr); end
            end
            accepted = req_b && ack_b && !stale && !redirect;
            if (accepted) begin
                n_tests++; if (addr_b !== flow) begin
                    n_fail++; $display("FAIL rand_flow got %h want %h", addr_b, flow); end
            end
            step();
            if (accepted) begin
                deliveries++;
                n_tests++; if (instr_valid !== 1'b1 || instr !== mem_word(addr_b)) begin
                    n_fail++; $display("FAIL rand_deliver got v=%b instr=%h want 1 %h", instr_valid, instr, mem_word(addr_b)); end
            end else if (req_b) begin
                n_tests++; if (instr_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rand_noaccept got v=%b want 0", instr_valid); end
            end
            if (req_b && ack_b) stale = 1'b0;
            if (req_b && redirect && !ack_b) stale = 1'b1;
            if (redirect) flow = target;
            else if (accepted) flow = addr_b + 32'd4;
            prev_wait = req_b && !ack_b;
            prev_addr = addr_b;
        end
        redirect = 1'b0; stall = 1'b0;
        n_tests++; if (deliveries < 100) begin
            n_fail++; $display("FAIL rand_liveness got %0d deliveries want >=100", deliveries); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_align();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS datapath. Holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents the fetched instruction to the IF/ID pipeline register. It drives `pc_plus4` into input A of the 32-bit 2:1 next-PC select mux and takes that mux's output back as `npc`. It supports hazard stalls and branch/jump redirects, including a redirect that arrives while a fetch is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `npc` in 32: next PC from the next-PC select mux.
- `redirect` in 1: `npc` is a taken branch/jump target; flush the current fetch.
- `stall` in 1: hazard-unit hold; do not advance.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, stable while `imem_req` is high.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle (may be the same cycle as the request).
- `imem_rdata` in 32: instruction word.
- `pc` out 32: current fetch PC register.
- `pc_plus4` out 32: `pc + 4`, combinational, modulo 2^32.
- `instr` out 32: captured instruction (registered).
- `instr_valid` out 1: `instr` is valid for IF/ID.

## Operation
- **Reset values:** `pc=RESET_PC`, `imem_addr=RESET_PC`, `imem_req=0`, `instr=0`, `instr_valid=0`, state IDLE.
- **States:** IDLE, REQ, HOLD, DISCARD.
- **IDLE:** move to REQ on the next edge, with `imem_addr<=pc`.
- **REQ:** `imem_req=1`.
  - `imem_ack & !redirect & !stall`: `instr<=imem_rdata`, `instr_valid<=1`, `pc<=npc`, `imem_addr<=npc`, stay in REQ.
  - `imem_ack & !redirect & stall`: capture `instr`, `instr_valid<=1`, pc held, go to HOLD.
  - `redirect & imem_ack`: drop data, `instr_valid<=0`, `pc<=npc`, `imem_addr<=npc`, stay in REQ.
  - `redirect & !imem_ack`: `pc<=npc`, `instr_valid<=0`, `imem_addr` held, go to DISCARD.
- **HOLD:** `imem_req=0`; `instr` and `instr_valid` are held.
  - `!stall`: `pc<=npc`, `imem_addr<=npc`, `instr_valid<=0`, go to REQ.
  - `redirect`: same as `!stall` (drops `instr`).
- **DISCARD:** `imem_req=1` at the old `imem_addr`.
  - On `imem_ack`: data is dropped, `imem_addr<=pc`, go to REQ.
  - A further `redirect` in DISCARD loads `pc<=npc` again.
- **`instr_valid` clearing:** in REQ, `instr_valid` clears on any edge without an accepted ack.
- **Priority:** redirect > stall > ack.
- **Reset mid-operation:** an outstanding request is abandoned immediately; memory must tolerate `imem_req` falling without ack.

## Timing
- Reset deasserted at edge 0: `imem_req` goes high after edge 1.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, `instr_valid` continuously high.
- `instr` latency: one cycle after `imem_ack`.
- `imem_addr` never changes while `imem_req=1` and no ack has been given.
- Redirect penalty: one bubble with zero-wait memory; one extra memory transaction when the redirect is taken in DISCARD.

## Configuration
- **`FETCH_ALIGN_EN` defined:** every PC load uses `{npc[31:2],2'b00}`, so `pc` and `imem_addr` are always word-aligned.
- **`FETCH_ALIGN_EN` undefined:** `npc` is loaded verbatim.

## Structure
- **Shared package `mips_pkg`:** fetch state enum (IDLE, REQ, HOLD, DISCARD), `WORD_W=32`, `INSTR_NOP=32'h0000_0000`.
- **Sub-module `pc_reg`:** PC register with load enable, alignment option and `+4` adder. The FSM and handshake live in `fetch_unit`.

## Test plan
- **Reset:** `RESET_PC=32'h0040_0000`, zero-wait ack, `npc=pc_plus4` -> `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008; `instr_valid` high from the cycle after the first ack.
- **Stall:** stall held 3 cycles at ack of 0x00400008 -> `instr` stable for 3 cycles, `pc` stays 0x00400008, `imem_req=0`; fetch of 0x0040000C on the cycle after stall drops.
- **Redirect with wait-state memory:** `redirect` with `npc=0x00400100` while the ack for 0x00400010 is delayed 2 cycles -> `imem_addr` holds 0x00400010 until ack, data dropped (`instr_valid=0`), next request 0x00400100.
- **Redirect and stall together:** `redirect` and `stall` in HOLD -> redirect wins, `pc=npc`, `instr_valid=0`.
- **Wrap-around:** `pc=32'hFFFF_FFFC` -> `pc_plus4=0`, next fetch at 0x00000000.
- **Alignment:** `npc=0x00400103` with `FETCH_ALIGN_EN` -> `imem_addr=0x00400100`; without it -> 0x00400103.
